rf_dump_reader: RTL and testbench



---
 rtl/rf_dump_reader_pkg.sv | 7 +
 rtl/rf_dump_reader.sv | 102 ++++++++++
 tb/tb_rf_dump_reader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dump_reader_pkg.sv
// rf_dump_reader_pkg: shared register-file geometry and dump-engine state encoding
package rf_dump_reader_pkg;
    // Register file geometry, also used by the register file and the core top
    localparam int RF_AW = 5;
    localparam int RF_DW = 32;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_SEND, ST_DONE} state_e;
endpackage

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks a register index range through the RF debug read port and streams each value out
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, first_idx, last_idx  dump request and inclusive index range, sampled in IDLE
//   abort                    cancels a dump in progress
//   reg_sel / reg_data       register file read port (combinational data)
//   dout_*                   valid/ready word stream tagged with index and last flag
//   busy, done               activity flag and end-of-dump pulse
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] first_idx,
    input  logic [AW-1:0] last_idx,
    input  logic          abort,
    output logic [AW-1:0] reg_sel,
    input  logic [DW-1:0] reg_data,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic [AW-1:0] dout_idx,
    output logic          dout_last,
    output logic          busy,
    output logic          done
);
    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] end_q, end_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          last_q, last_d;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        end_d   = end_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // An empty range skips straight to DONE and leaves reg_sel untouched
                if (start && first_idx <= last_idx) begin
                    cur_d   = first_idx;
                    end_d   = last_idx;
                    state_d = ST_READ;
                end else if (start) begin
                    state_d = ST_DONE;
                end
            end
            ST_READ: begin
                data_d  = reg_data;
                idx_d   = cur_q;
                last_d  = cur_q == end_q;
                state_d = abort ? ST_IDLE : ST_SEND;
            end
            ST_SEND: begin
                // abort outranks a same-cycle handshake; cur never wraps since it stops at end
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dout_ready) begin
                    state_d = last_q ? ST_DONE : ST_READ;
                    cur_d   = last_q ? cur_q : cur_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            end_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            end_q   <= end_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // cur_q only changes on entry to READ, so it doubles as the registered read select
    assign reg_sel    = cur_q;
    assign dout_valid = state_q == ST_SEND;
    assign dout_data  = data_q;
    assign dout_idx   = idx_q;
    assign dout_last  = last_q;
    assign busy       = state_q != ST_IDLE;
    assign done       = state_q == ST_DONE;
endmodule

// File: tb/tb_rf_dump_reader.sv
// tb_rf_dump_reader: directed stimulus with a transaction-level model checked every cycle
module tb_rf_dump_reader;
    import rf_dump_reader_pkg::*;
    localparam int AW = RF_AW;
    localparam int DW = RF_DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b0;
    logic [AW-1:0] first_idx = '0;
    logic [AW-1:0] last_idx = '0;
    logic [AW-1:0] reg_sel, dout_idx;
    logic [DW-1:0] reg_data, dout_data;
    logic          dout_valid, dout_last, busy, done;

    logic [DW-1:0] rf [0:31];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state
    int   q[$];
    int   m_end;
    logic m_act = 1'b0;
    logic m_show = 1'b0;
    logic m_done = 1'b0;
    logic nd;
    // logs for literal checks
    int          acc_idx[$];
    logic [31:0] acc_data[$];
    logic        acc_last[$];
    int n_done = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    logic bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    rf_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .last_idx(last_idx),
        .abort(abort), .reg_sel(reg_sel), .reg_data(reg_data), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_data(dout_data), .dout_idx(dout_idx), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign reg_data = (reg_sel == 0) ? '0 : rf[reg_sel];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a dump is a queue of indices; each word takes a gap cycle then is shown until accepted
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_act = 1'b0;
            m_show = 1'b0;
            m_done = 1'b0;
            chk("rst_valid", dout_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_outs", {reg_sel, dout_idx, dout_last, dout_data}, 0);
        end else begin
            chk("valid", dout_valid, m_show);
            chk("busy", busy, m_act || m_done);
            chk("done", done, m_done);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (m_show) begin
                chk("idx", dout_idx, q[0]);
                chk("data", dout_data, q[0] == 0 ? 32'h0 : rf[q[0]]);
                chk("last", dout_last, q[0] == m_end);
            end
            nd = 1'b0;
            if (abort && (m_act || m_done)) begin
                q.delete();
                m_act = 1'b0;
                m_show = 1'b0;
            end else if (!m_act && !m_done && start) begin
                start_cyc = cyc;
                if (first_idx <= last_idx) begin
                    for (int i = int'(first_idx); i <= int'(last_idx); i++) q.push_back(i);
                    m_end = int'(last_idx);
                    m_act = 1'b1;
                    m_show = 1'b0;
                end else begin
                    nd = 1'b1;
                end
            end else if (m_act) begin
                if (!m_show) begin
                    m_show = 1'b1;
                end else if (dout_ready) begin
                    acc_idx.push_back(q[0]);
                    acc_data.push_back(dout_data);
                    acc_last.push_back(dout_last);
                    void'(q.pop_front());
                    m_show = 1'b0;
                    if (q.size() == 0) begin
                        m_act = 1'b0;
                        nd = 1'b1;
                    end
                end
            end
            m_done = nd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int f, input int l);
        first_idx = AW'(f);
        last_idx = AW'(l);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || done) && k < 300) begin
            tick(1);
            k++;
        end
        chk("idle_wait", busy, 0);
        tick(1);
    endtask

    task automatic clear_logs();
        acc_idx.delete();
        acc_data.delete();
        acc_last.delete();
        n_done = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        #1;
        chk("t1_valid", dout_valid, 0);
        chk("t1_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;

        // full dump 0..31
        dout_ready = 1'b1;
        clear_logs();
        do_start(0, 31);
        wait_idle();
        chk("full_count", acc_idx.size(), 32);
        chk("full_w0", acc_data[0], 0);
        chk("full_w1", acc_data[1], 32'h1000_0001);
        chk("full_w31", acc_data[31], 32'h1000_001F);
        chk("full_idx31", acc_idx[31], 31);
        chk("full_last31", acc_last[31], 1);
        chk("full_last30", acc_last[30], 0);
        chk("full_done_lat", done_cyc - start_cyc, 65);
        chk("full_ndone", n_done, 1);

        // backpressure 5..7
        clear_logs();
        do_start(5, 7);
        for (int k = 0; k < 60 && (busy || done); k++) begin
            dout_ready = bp[k % 4];
            tick(1);
        end
        dout_ready = 1'b1;
        tick(1);
        chk("bp_count", acc_idx.size(), 3);
        chk("bp_idx0", acc_idx[0], 5);
        chk("bp_idx1", acc_idx[1], 6);
        chk("bp_idx2", acc_idx[2], 7);
        chk("bp_data2", acc_data[2], 32'h1000_0007);

        // empty range
        clear_logs();
        do_start(9, 3);
        chk("empty_busy", busy, 1);
        chk("empty_done", done, 1);
        wait_idle();
        chk("empty_count", acc_idx.size(), 0);
        chk("empty_ndone", n_done, 1);
        chk("empty_lat", done_cyc - start_cyc, 1);

        // start while busy is ignored
        clear_logs();
        do_start(2, 4);
        tick(2);
        do_start(0, 31);
        wait_idle();
        chk("busy_count", acc_idx.size(), 3);
        chk("busy_idx0", acc_idx[0], 2);
        chk("busy_idx2", acc_idx[2], 4);
        chk("busy_ndone", n_done, 1);

        // abort in SEND on idx 10
        clear_logs();
        do_start(8, 15);
        for (int k = 0; k < 40 && !(dout_valid && dout_idx == 10); k++) tick(1);
        chk("abort_reach", dout_idx, 10);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_valid", dout_valid, 0);
        chk("abort_busy", busy, 0);
        tick(3);
        chk("abort_ndone", n_done, 0);
        chk("abort_count", acc_idx.size(), 2);
        clear_logs();
        do_start(0, 0);
        wait_idle();
        chk("one_count", acc_idx.size(), 1);
        chk("one_last", acc_last[0], 1);
        chk("one_data", acc_data[0], 0);
        chk("one_ndone", n_done, 1);

        // concurrent write to r[12]
        clear_logs();
        do_start(10, 14);
        for (int k = 0; k < 40 && !(dout_valid && dout_idx == 11); k++) tick(1);
        @(negedge clk);
        rf[12] = 32'hDEAD_BEEF;
        wait_idle();
        chk("cw_idx", acc_idx[2], 12);
        chk("cw_data", acc_data[2], 32'hDEAD_BEEF);
        chk("cw_data13", acc_data[3], 32'h1000_000D);

        // reset mid-dump
        clear_logs();
        dout_ready = 1'b0;
        do_start(3, 5);
        tick(1);
        chk("pre_rst_valid", dout_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", {reg_sel, dout_idx, dout_last, dout_data}, 0);
        tick(1);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        clear_logs();
        do_start(1, 2);
        wait_idle();
        chk("post_rst_count", acc_idx.size(), 2);
        chk("post_rst_idx0", acc_idx[0], 1);
        chk("post_rst_idx1", acc_idx[1], 2);
        chk("post_rst_ndone", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
